// File: rtl/multicycle_main_control_if.sv
// Control bus between the multicycle main control FSM and the datapath/memory.
interface multicycle_main_control_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUop;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  Op, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUop, RegDst, MemtoReg, RegWrite,
           illegal_op, state_dbg
  );

  modport slave (
    output Op, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
           ALUSrcA, ALUSrcB, ALUop, RegDst, MemtoReg, RegWrite,
           illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback and stalls memory states on mem_ready.
module multicycle_main_control #(
  parameter bit EN_ADDI = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  multicycle_main_control_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state, state_nxt, dec_state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = EN_ADDI ? S_ADDIEX : S_FETCH;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Outputs decode as FETCH while in reset so the datapath sees a quiet fetch setup.
  assign dec_state = rst ? S_FETCH : state;

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.PCSrc      = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUop      = 2'b00;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.illegal_op = 1'b0;
    case (dec_state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: bus.illegal_op = 1'b0;
          OP_ADDI: bus.illegal_op = !EN_ADDI;
          default: bus.illegal_op = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUop   = 2'b10;
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUop   = 2'b01;
        bus.PCSrc   = 2'b01;
        bus.Branch  = 1'b1;
      end
      S_JUMP: begin
        bus.PCSrc   = 2'b10;
        bus.PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.mem_req    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.PCWrite    = 1'b0;
      bus.Branch     = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.illegal_op = 1'b0;
    end
  end

  assign bus.state_dbg = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control; a second instance covers EN_ADDI=0.
module tb_multicycle_main_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  multicycle_main_control_if bus ();
  multicycle_main_control_if bus2 ();

  multicycle_main_control #(.EN_ADDI(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  multicycle_main_control #(.EN_ADDI(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.Op = 6'b000000; bus.mem_ready = 1'b1;
    bus2.Op = 6'b001000; bus2.mem_ready = 1'b1;
    rst = 1'b1;
    tick();
    #2;
    checks++;
    if (bus.state_dbg !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
    checks++;
    if ({bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.Branch, bus.RegWrite, bus.illegal_op} !== 7'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000000",
        {bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.Branch, bus.RegWrite, bus.illegal_op});
    end
    checks++;
    if (bus.ALUSrcB !== 2'b01) begin failures++; $display("FAIL reset_alusrcb got=%b exp=01", bus.ALUSrcB); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL first_fetch_req got=%b exp=1", bus.mem_req); end
  endtask

  task automatic test_rtype();
    int exp_st[5] = '{0, 1, 6, 7, 0};
    go_reset();
    bus.Op = 6'b000000; bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if (bus.state_dbg !== 4'(exp_st[i])) begin failures++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_st[i]); end
      checks++;
      if ({bus.RegWrite, bus.RegDst} !== ((exp_st[i] == 7) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL rtype_regwr[%0d] got=%b", i, {bus.RegWrite, bus.RegDst});
      end
      if (exp_st[i] == 6) begin
        checks++;
        if (bus.ALUop !== 2'b10) begin failures++; $display("FAIL rtype_aluop got=%b exp=10", bus.ALUop); end
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    int exp_st[8] = '{0, 0, 0, 1, 2, 3, 3, 4};
    bit mr[8]     = '{0, 0, 1, 1, 1, 0, 1, 1};
    int irw = 0, pcw = 0;
    go_reset();
    bus.Op = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr[i];
      #2;
      checks++;
      if (bus.state_dbg !== 4'(exp_st[i])) begin failures++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_st[i]); end
      irw += int'(bus.IRWrite);
      pcw += int'(bus.PCWrite);
      if (exp_st[i] == 4) begin
        checks++;
        if ({bus.MemtoReg, bus.RegWrite, bus.RegDst} !== 3'b110) begin failures++; $display("FAIL lw_memwb got=%b exp=110", {bus.MemtoReg, bus.RegWrite, bus.RegDst}); end
      end
      if (exp_st[i] == 3) begin
        checks++;
        if ({bus.mem_req, bus.IorD, bus.MemWrite} !== 3'b110) begin failures++; $display("FAIL lw_memrd got=%b exp=110", {bus.mem_req, bus.IorD, bus.MemWrite}); end
      end
      tick();
    end
    #2;
    checks++;
    if (bus.state_dbg !== 4'd0) begin failures++; $display("FAIL lw_end got=%0d exp=0", bus.state_dbg); end
    checks++;
    if (irw != 1 || pcw != 1) begin failures++; $display("FAIL lw_fetch_once irw=%0d pcw=%0d exp=1", irw, pcw); end
  endtask

  task automatic test_sw_wait();
    int exp_st[7] = '{0, 1, 2, 5, 5, 5, 5};
    bit mr[7]     = '{1, 1, 1, 0, 0, 0, 1};
    int mw = 0;
    go_reset();
    bus.Op = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = mr[i];
      #2;
      checks++;
      if (bus.state_dbg !== 4'(exp_st[i])) begin failures++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, bus.state_dbg, exp_st[i]); end
      checks++;
      if ({bus.MemWrite, bus.IorD} !== ((exp_st[i] == 5) ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL sw_memwrite[%0d] got=%b", i, {bus.MemWrite, bus.IorD});
      end
      if (bus.MemWrite === 1'b1) mw++;
      tick();
    end
    #2;
    checks++;
    if (bus.state_dbg !== 4'd0 || mw != 4) begin failures++; $display("FAIL sw_end state=%0d mw_cycles=%0d exp 0/4", bus.state_dbg, mw); end
  endtask

  task automatic test_beq_j();
    go_reset();
    bus.Op = 6'b000100; bus.mem_ready = 1'b1;
    tick(); tick();
    #2;
    checks++;
    if ({bus.state_dbg, bus.ALUop, bus.Branch, bus.PCSrc, bus.ALUSrcA} !== {4'd8, 2'b01, 1'b1, 2'b01, 1'b1}) begin
      failures++; $display("FAIL beq_branch got=%h/%b/%b/%b exp=8/01/1/01", bus.state_dbg, bus.ALUop, bus.Branch, bus.PCSrc);
    end
    tick();
    #2;
    checks++;
    if (bus.state_dbg !== 4'd0) begin failures++; $display("FAIL beq_return got=%0d exp=0", bus.state_dbg); end
    bus.Op = 6'b000010;
    tick(); tick();
    #2;
    checks++;
    if ({bus.state_dbg, bus.PCWrite, bus.PCSrc, bus.Branch} !== {4'd11, 1'b1, 2'b10, 1'b0}) begin
      failures++; $display("FAIL j_jump got=%0d/%b/%b exp=11/1/10", bus.state_dbg, bus.PCWrite, bus.PCSrc);
    end
    tick();
    #2;
    checks++;
    if (bus.state_dbg !== 4'd0) begin failures++; $display("FAIL j_return got=%0d exp=0", bus.state_dbg); end
  endtask

  task automatic test_illegal_addi();
    int exp_st[5] = '{0, 1, 9, 10, 0};
    go_reset();
    bus.Op = 6'b111111; bus.mem_ready = 1'b1;
    bus2.Op = 6'b001000; bus2.mem_ready = 1'b1;
    #2;
    checks++;
    if (bus.illegal_op !== 1'b0 || bus2.illegal_op !== 1'b0) begin failures++; $display("FAIL illegal_fetch got=%b%b exp=00", bus.illegal_op, bus2.illegal_op); end
    tick();
    #2;
    checks++;
    if (bus.state_dbg !== 4'd1 || bus.illegal_op !== 1'b1) begin failures++; $display("FAIL illegal_decode state=%0d ill=%b exp 1/1", bus.state_dbg, bus.illegal_op); end
    checks++;
    if (bus2.state_dbg !== 4'd1 || bus2.illegal_op !== 1'b1) begin failures++; $display("FAIL addi_off_decode state=%0d ill=%b exp 1/1", bus2.state_dbg, bus2.illegal_op); end
    tick();
    #2;
    checks++;
    if (bus.state_dbg !== 4'd0 || bus.illegal_op !== 1'b0) begin failures++; $display("FAIL illegal_next state=%0d ill=%b exp 0/0", bus.state_dbg, bus.illegal_op); end
    checks++;
    if (bus2.state_dbg !== 4'd0 || bus2.illegal_op !== 1'b0) begin failures++; $display("FAIL addi_off_next state=%0d ill=%b exp 0/0", bus2.state_dbg, bus2.illegal_op); end
    go_reset();
    bus.Op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++;
      if (bus.state_dbg !== 4'(exp_st[i]) || bus.illegal_op !== 1'b0) begin
        failures++; $display("FAIL addi_state[%0d] got=%0d ill=%b exp=%0d", i, bus.state_dbg, bus.illegal_op, exp_st[i]);
      end
      if (exp_st[i] == 9) begin
        checks++;
        if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUop} !== 5'b11000) begin failures++; $display("FAIL addi_ex got=%b exp=11000", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUop}); end
      end
      if (exp_st[i] == 10) begin
        checks++;
        if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b100) begin failures++; $display("FAIL addi_wb got=%b exp=100", {bus.RegWrite, bus.RegDst, bus.MemtoReg}); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    go_reset();
    bus.Op = 6'b101011; bus.mem_ready = 1'b1;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    #2;
    checks++;
    if (bus.state_dbg !== 4'd5 || bus.MemWrite !== 1'b1) begin failures++; $display("FAIL midrst_pre state=%0d mw=%b exp 5/1", bus.state_dbg, bus.MemWrite); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL midrst_drop mw=%b req=%b exp 0/0", bus.MemWrite, bus.mem_req); end
    tick();
    #2;
    checks++;
    if (bus.state_dbg !== 4'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", bus.state_dbg); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      checks++;
      if (bus.RegWrite !== 1'b0 || bus.state_dbg !== 4'd0) begin failures++; $display("FAIL midrst_after[%0d] rw=%b state=%0d exp 0/0", i, bus.RegWrite, bus.state_dbg); end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_beq_j();
    test_illegal_addi();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached exp=finish");
    $fatal(1, "timeout");
  end
endmodule
